instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl_if.sv | 41 ++++
 rtl/instr_fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory port, redirect input, decode handshake and status.
// master = fetch controller side, slave = memory/decode/environment side.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic                   fault;
  logic [ADDR_WIDTH-1:0]  fault_addr;
  logic [31:0]            perf_fetch_cnt;
  logic [31:0]            perf_stall_cnt;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc,
    output fault, fault_addr,
    output perf_fetch_cnt, perf_stall_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc,
    input  fault, fault_addr,
    input  perf_fetch_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Single-entry instruction fetch controller: BOOT/RUN/FAULT FSM, one-deep output register, redirects.
// Optional saturating perf counters are built only when INSTR_FETCH_PERF_CNT_EN is defined.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_SIZE   = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_rsp_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  fetch_rsp_t            rsp_q, rsp_d;
  logic                  out_valid_q, out_valid_d;

  logic [63:0] word_idx;
  logic        in_range, active, issue_slot;
  logic        fire, range_fault, redir_ok, redir_bad;

  // Word index widened so the bound compare never truncates ADDR_SIZE.
  assign word_idx    = 64'(pc_q >> 2);
  assign in_range    = (word_idx < 64'(ADDR_SIZE));
  assign active      = (state_q != FAULT);
  assign redir_ok    = active && bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad   = active && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign issue_slot  = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !bus.redirect_valid;
  assign fire        = issue_slot && in_range;
  assign range_fault = issue_slot && !in_range;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = redir_bad ? FAULT : RUN;
      RUN:     if (redir_bad || range_fault) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.imem_addr  = pc_q;
    bus.out_valid  = out_valid_q;
    bus.out_instr  = rsp_q.instr;
    bus.out_pc     = rsp_q.pc;
    bus.fault      = (state_q == FAULT);
    bus.fault_addr = fault_addr_q;
  end

  // Redirect outranks fetch and hold; a held instruction is discarded by any redirect or fault.
  always_comb begin
    pc_d         = pc_q;
    rsp_d        = rsp_q;
    out_valid_d  = out_valid_q;
    fault_addr_d = fault_addr_q;
    if (redir_bad) begin
      fault_addr_d = bus.redirect_pc;
      out_valid_d  = 1'b0;
    end else if (redir_ok) begin
      pc_d        = bus.redirect_pc;
      out_valid_d = 1'b0;
    end else if (range_fault) begin
      fault_addr_d = pc_q;
      out_valid_d  = 1'b0;
    end else if (fire) begin
      rsp_d.pc    = pc_q;
      rsp_d.instr = bus.imem_instr;
      out_valid_d = 1'b1;
      pc_d        = pc_q + ADDR_WIDTH'(4);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      rsp_q        <= '0;
      out_valid_q  <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      rsp_q        <= rsp_d;
      out_valid_q  <= out_valid_d;
      fault_addr_q <= fault_addr_d;
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fire && (fetch_cnt_q != '1))                           fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.perf_fetch_cnt = fetch_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  assign bus.perf_fetch_cnt = '0;
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: stimulus predicts the accepted-instruction stream, a negedge monitor checks it.
module tb_instr_fetch_ctrl;
  localparam int AW   = 8;
  localparam int IW   = 32;
  localparam int SIZE = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch_ctrl #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .ADDR_SIZE(SIZE), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [IW-1:0] mem [SIZE];
  assign bus.imem_instr = mem[bus.imem_addr[5:2]];

  // Expected stream: sequential instructions from the last redirect target, ending in a fault marker.
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    bit            is_fault;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   faulted;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_run(input logic [AW-1:0] start);
    exp_t e;
    int   a;
    a = int'(start);
    while (a < SIZE * 4) begin
      e.pc = AW'(a); e.instr = mem[a / 4]; e.is_fault = 1'b0;
      q.push_back(e);
      a += 4;
    end
    e.pc = AW'(a); e.instr = '0; e.is_fault = 1'b1;
    q.push_back(e);
  endfunction

  // Drives one cycle of inputs, then applies what the coming edge does to the expected stream.
  task automatic step(input bit rv, input logic [AW-1:0] rpc, input bit rdy);
    exp_t e;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      faulted = 1'b0;
      push_run(8'h00);
    end else if (rv && !faulted) begin
      q.delete();
      if (rpc[1:0] != 2'b00) begin
        e.pc = rpc; e.instr = '0; e.is_fault = 1'b1;
        q.push_back(e);
        faulted = 1'b1;
      end else begin
        push_run(rpc);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 8'h20, 1'b1);
    chk("rst_out_valid",  bus.out_valid,      0);
    chk("rst_fault",      bus.fault,          0);
    chk("rst_fault_addr", bus.fault_addr,     0);
    chk("rst_out_pc",     bus.out_pc,         0);
    chk("rst_out_instr",  bus.out_instr,      0);
    chk("rst_imem_addr",  bus.imem_addr,      0);
    chk("rst_perf_fetch", bus.perf_fetch_cnt, 0);
    chk("rst_perf_stall", bus.perf_stall_cnt, 0);
    step(1'b1, 8'h24, 1'b1);
    rst = 1'b0;
  endtask

  task automatic chk_perf_const(input string nm, input int fires, input int stalls);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk({nm, "_fetch"}, bus.perf_fetch_cnt, 64'(fires));
    chk({nm, "_stall"}, bus.perf_stall_cnt, 64'(stalls));
`else
    chk({nm, "_fetch"}, bus.perf_fetch_cnt, 64'(fires * 0));
    chk({nm, "_stall"}, bus.perf_stall_cnt, 64'(stalls * 0));
`endif
  endtask

  // Monitor state
  logic [AW-1:0] hold_pc, exp_faddr;
  logic [IW-1:0] hold_instr;
  bit            hold_prev, seen_fault, fault_due, prev_v, prev_acc, perf_req;
  int            idle, m_fire, m_stall;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0; seen_fault = 0; fault_due = 0; prev_v = 0; prev_acc = 0;
      idle = 0; m_fire = 0; m_stall = 0;
    end else begin
      if (bus.out_valid && (!prev_v || prev_acc)) m_fire++;
      if (perf_req) begin
        perf_req = 0;
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("perf_fetch_model", bus.perf_fetch_cnt, 64'(m_fire));
        chk("perf_stall_model", bus.perf_stall_cnt, 64'(m_stall));
`else
        chk("perf_fetch_model", bus.perf_fetch_cnt, 64'(m_fire * 0));
        chk("perf_stall_model", bus.perf_stall_cnt, 64'(m_stall * 0));
`endif
      end
      if (fault_due) chk("fault_on_time", bus.fault, 1);
      if (bus.fault) begin
        if (!seen_fault) begin
          seen_fault = 1; faulted = 1;
          if (q.size() == 0 || !q[0].is_fault) begin
            total++; bad++;
            $display("FAIL fault_unexpected: fault_addr=%0h with no fault predicted (t=%0t)", bus.fault_addr, $time);
            exp_faddr = bus.fault_addr;
          end else begin
            exp_faddr = q[0].pc;
            void'(q.pop_front());
          end
        end
        chk("fault_addr", bus.fault_addr, exp_faddr);
        chk("fault_no_valid", bus.out_valid, 0);
      end
      if (hold_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_pc",    bus.out_pc,    hold_pc);
        chk("hold_instr", bus.out_instr, hold_instr);
      end
      if (bus.out_valid) begin
        if (q.size() == 0 || q[0].is_fault) begin
          total++; bad++;
          $display("FAIL valid_unexpected: out_pc=%0h with no instruction predicted (t=%0t)", bus.out_pc, $time);
        end else begin
          chk("out_pc",    bus.out_pc,    q[0].pc);
          chk("imem_addr", bus.imem_addr, q[0].pc + 8'd4);
          if (bus.out_ready) begin
            chk("acc_instr", bus.out_instr, q[0].instr);
            void'(q.pop_front());
          end
        end
      end
      fault_due = !bus.fault && !bus.redirect_valid && (q.size() > 0) && q[0].is_fault &&
                  (!bus.out_valid || bus.out_ready);
      if (!bus.out_valid && !bus.fault && !bus.redirect_valid) idle++;
      else idle = 0;
      if (idle > 3) begin
        chk("progress_idle_cycles", 64'(idle), 3);
        idle = 0;
      end
      if (bus.out_valid && !bus.out_ready) m_stall++;
      hold_prev  = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
      hold_pc    = bus.out_pc;
      hold_instr = bus.out_instr;
      prev_v     = bus.out_valid;
      prev_acc   = bus.out_valid && bus.out_ready;
    end
  end

  initial begin
    bit            rv, rdy;
    logic [AW-1:0] rpc;
    int            fault_age;
    rst = 1'b1;
    perf_req = 0;
    faulted = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    @(posedge clk); #1;

    // Latency after reset and a straight run into the end of memory.
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    chk("boot_valid", bus.out_valid, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("first_valid", bus.out_valid, 1);
    chk("first_pc",    bus.out_pc,    8'h00);
    chk("first_instr", bus.out_instr, mem[0]);
    step(1'b0, 8'h00, 1'b1);
    chk("second_pc", bus.out_pc, 8'h04);
    step(1'b0, 8'h00, 1'b1);
    chk("third_pc", bus.out_pc, 8'h08);
    for (int i = 0; i < 40 && !bus.fault; i++) step(1'b0, 8'h00, 1'b1);
    chk("seq_fault",      bus.fault,      1);
    chk("seq_fault_addr", bus.fault_addr, 8'h40);
    chk_perf_const("seq_perf", 16, 0);

    // Stall at 0x08, resume, then redirect over a held instruction.
    do_reset();
    for (int i = 0; i < 10 && !(bus.out_valid && bus.out_pc == 8'h08); i++) step(1'b0, 8'h00, 1'b1);
    chk("stall_start_pc", bus.out_pc, 8'h08);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_pc",    bus.out_pc,    8'h08);
      chk("stall_instr", bus.out_instr, mem[2]);
      chk("stall_imem",  bus.imem_addr, 8'h0C);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("resume_pc", bus.out_pc, 8'h0C);
    step(1'b0, 8'h00, 1'b1);
    chk("resume_pc2", bus.out_pc, 8'h10);
    chk_perf_const("stall_perf", 5, 3);
    step(1'b1, 8'h20, 1'b0);
    chk("redir_flush", bus.out_valid, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("redir_valid", bus.out_valid, 1);
    chk("redir_pc",    bus.out_pc,    8'h20);
    chk("redir_instr", bus.out_instr, mem[8]);

    // Misaligned redirect: sticky fault, redirects ignored, reset clears it.
    step(1'b1, 8'h22, 1'b1);
    chk("mis_fault",      bus.fault,      1);
    chk("mis_fault_addr", bus.fault_addr, 8'h22);
    chk("mis_valid",      bus.out_valid,  0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, AW'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)));
      chk("mis_hold_fault", bus.fault,      1);
      chk("mis_hold_addr",  bus.fault_addr, 8'h22);
      chk("mis_hold_valid", bus.out_valid,  0);
    end
    do_reset();

    // Random traffic against the scoreboard.
    fault_age = 0;
    for (int i = 0; i < 4000; i++) begin
      if ((faulted && fault_age > 12) || $urandom_range(0, 499) == 0) begin
        do_reset();
        fault_age = 0;
      end else begin
        rdy = ($urandom_range(0, 99) < 70);
        rv  = ($urandom_range(0, 99) < 6);
        rpc = AW'($urandom_range(0, 19) * 4);
        if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        step(rv, rpc, rdy);
        if (faulted) fault_age++;
      end
      if (i % 500 == 499) perf_req = 1;
    end
    perf_req = 1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
